// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding and protocol constants.
package i2c_pkg;

  localparam int   I2C_BYTE_BITS = 8;
  localparam logic I2C_RW_READ   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    WAIT_STOP
  } i2c_slave_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser for an asynchronous bus line followed by a registered
// edge detector. level/rise/fall are mutually aligned: in the cycle a strobe
// is high, level already shows the new value.
module i2c_sync_edge #(
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;

  // Resetting to the bus idle level avoids a spurious edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= {2{IDLE_LVL}};
      level <= IDLE_LVL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[0], din};
      level <= sync[1];
      rise  <= sync[1] & ~level;
      fall  <= ~sync[1] & level;
    end
  end

endmodule

// File: rtl/i2c_slave.sv
// I2C target with a fixed 7-bit address. Bus lines are oversampled on clk;
// data is sampled on SCL rise and SDA is only changed on SCL fall.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl (
    .clk(clk), .rst(rst), .din(scl),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync_edge u_sda (
    .clk(clk), .rst(rst), .din(sda_in),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_slave_state_t state, state_nxt;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shreg, shreg_nxt, rx_data_nxt, byte_in;
  logic       sda_oe_nxt, rx_valid_nxt, tx_req_nxt, busy_nxt;
  logic       rw, rw_nxt, ack_hold, ack_hold_nxt, load_tx;
  logic       start_ev, stop_ev, last_bit, full_cnt, addr_hit;

  assign start_ev = sda_fall & scl_lvl;
  assign stop_ev  = sda_rise & scl_lvl;
  assign byte_in  = {shreg[6:0], sda_lvl};
  assign last_bit = (bit_cnt == 4'(I2C_BYTE_BITS - 1));
  assign full_cnt = (bit_cnt == 4'(I2C_BYTE_BITS));
  assign addr_hit = (byte_in[7:1] == SLAVE_ADDR);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; STOP then START override any bit event in the same cycle.
  // ack_hold marks the second half of an ACK slot (SDA already driven, or
  // master ACK seen in READ_ACK).
  always_comb begin
    state_nxt = state;
    if (stop_ev) state_nxt = IDLE;
    else if (start_ev) state_nxt = ADDR;
    else begin
      unique case (state)
        ADDR:      if (scl_rise && last_bit) state_nxt = addr_hit ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK:  if (scl_fall && ack_hold) state_nxt = (rw == I2C_RW_READ) ? READ : WRITE;
        WRITE:     if (scl_rise && last_bit) state_nxt = WRITE_ACK;
        WRITE_ACK: if (scl_fall && ack_hold) state_nxt = WRITE;
        READ:      if (scl_fall && full_cnt) state_nxt = READ_ACK;
        READ_ACK: begin
          if (scl_rise && sda_lvl)       state_nxt = WAIT_STOP;
          else if (scl_fall && ack_hold) state_nxt = READ;
        end
        default: ;
      endcase
    end
  end

  // Next values for the datapath and output registers
  always_comb begin
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    sda_oe_nxt   = sda_oe;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    tx_req_nxt   = 1'b0;
    busy_nxt     = busy;
    rw_nxt       = rw;
    ack_hold_nxt = ack_hold;
    load_tx      = 1'b0;
    if (stop_ev) begin
      bit_cnt_nxt  = '0;
      sda_oe_nxt   = 1'b0;
      busy_nxt     = 1'b0;
      ack_hold_nxt = 1'b0;
    end else if (start_ev) begin
      // busy is left alone so it stays high across a repeated START
      bit_cnt_nxt  = '0;
      sda_oe_nxt   = 1'b0;
      ack_hold_nxt = 1'b0;
    end else begin
      unique case (state)
        ADDR: if (scl_rise) begin
          shreg_nxt   = byte_in;
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (last_bit) begin
            bit_cnt_nxt = '0;
            rw_nxt      = byte_in[0];
            busy_nxt    = addr_hit;
          end
        end
        ADDR_ACK, WRITE_ACK: if (scl_fall) begin
          if (!ack_hold) begin
            sda_oe_nxt   = 1'b1;
            ack_hold_nxt = 1'b1;
          end else begin
            ack_hold_nxt = 1'b0;
            bit_cnt_nxt  = '0;
            if (state == ADDR_ACK && rw == I2C_RW_READ) load_tx = 1'b1;
            else sda_oe_nxt = 1'b0;
          end
        end
        WRITE: if (scl_rise) begin
          shreg_nxt   = byte_in;
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (last_bit) begin
            bit_cnt_nxt  = '0;
            rx_data_nxt  = byte_in;
            rx_valid_nxt = 1'b1;
          end
        end
        READ: if (scl_fall) begin
          // bit_cnt counts bits already placed on SDA
          if (full_cnt) begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = '0;
          end else begin
            shreg_nxt   = {shreg[6:0], 1'b0};
            sda_oe_nxt  = ~shreg[6];
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
        READ_ACK: begin
          if (scl_rise) begin
            if (sda_lvl) busy_nxt = 1'b0;
            else         ack_hold_nxt = 1'b1;
          end else if (scl_fall && ack_hold) begin
            ack_hold_nxt = 1'b0;
            load_tx      = 1'b1;
          end
        end
        default: ;
      endcase
      // Capture the user byte and put its MSB on the bus in one step
      if (load_tx) begin
        shreg_nxt   = tx_data;
        tx_req_nxt  = 1'b1;
        sda_oe_nxt  = ~tx_data[7];
        bit_cnt_nxt = 4'd1;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      sda_oe   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
      rw       <= 1'b0;
      ack_hold <= 1'b0;
    end else begin
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      sda_oe   <= sda_oe_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
      tx_req   <= tx_req_nxt;
      busy     <= busy_nxt;
      rw       <= rw_nxt;
      ack_hold <= ack_hold_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-level bus master drives directed and random
// transfers; expectations come from the protocol rules (target answers only
// 7'h50, ACKs every written byte, returns the planned user bytes on reads).
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam logic [6:0] SLAVE = 7'h50;
  localparam int         H     = 8;   // SCL half period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       sda_oe, rx_valid, tx_req, busy;
  logic [7:0] rx_data, tx_data;

  logic [7:0] plan   [0:255];
  logic [7:0] rx_log [0:255];
  logic [7:0] pay    [0:3];
  int n_vec = 0, n_err = 0;
  int tx_cnt = 0, rx_cnt = 0, oe_cnt = 0, busy_lo = 0, long_cnt = 0;
  logic rxv_d = 1'b0, txr_d = 1'b0;

  assign sda_bus = m_sda & ~sda_oe;
  assign tx_data = plan[tx_cnt[7:0]];

  i2c_slave #(.SLAVE_ADDR(SLAVE)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_req(tx_req), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // User-side monitor: logs received bytes, advances the tx plan on tx_req
  always @(negedge clk) begin
    rxv_d <= rx_valid;
    txr_d <= tx_req;
    if (rx_valid) begin
      rx_log[rx_cnt[7:0]] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_req)  tx_cnt  <= tx_cnt + 1;
    if (sda_oe)  oe_cnt  <= oe_cnt + 1;
    if (!busy)   busy_lo <= busy_lo + 1;
    if ((rx_valid && rxv_d) || (tx_req && txr_d)) long_cnt <= long_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    clks(2); m_sda = 1'b1; clks(H); scl = 1'b1; clks(H); m_sda = 1'b0; clks(H); scl = 1'b0;
  endtask

  task automatic do_stop();
    clks(2); m_sda = 1'b0; clks(H); scl = 1'b1; clks(H); m_sda = 1'b1; clks(H);
  endtask

  // One SCL period: drive b while low, sample bus and sda_oe mid-high
  task automatic bit_io(input logic b, output logic smp, output logic oe);
    clks(2); m_sda = b; clks(H - 2); scl = 1'b1;
    clks(H / 2); smp = sda_bus; oe = sda_oe;
    clks(H / 2); scl = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack, output logic oe);
    logic s, o;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s, o);
    bit_io(1'b1, ack, oe);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    logic s, o;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      bit_io(1'b1, s, o);
      b = {b[6:0], s};
    end
    bit_io(nack, s, o);
  endtask

  // Full transfer: START, address, n data bytes (last read byte NACKed), optional STOP
  task automatic transfer(input logic [6:0] a, input logic rd, input int n, input logic fin);
    logic hit, ack, oe;
    logic [7:0] b;
    int tx0, rx0, oe0, lg0;
    hit = (a == SLAVE);
    tx0 = tx_cnt; rx0 = rx_cnt; oe0 = oe_cnt; lg0 = long_cnt;
    for (int i = 0; i < 4; i++) plan[8'(tx0 + i)] = pay[i];
    do_start();
    wr_byte({a, rd}, ack, oe);
    chk("addr_ack", 32'(ack), 32'(!hit));
    chk("addr_oe", 32'(oe), 32'(hit));
    chk("busy_on", 32'(busy), 32'(hit));
    for (int i = 0; i < n; i++) begin
      if (!rd) begin
        wr_byte(pay[i], ack, oe);
        chk("data_ack", 32'(ack), 32'(!hit));
        chk("data_oe", 32'(oe), 32'(hit));
      end else begin
        rd_byte(i == n - 1, b);
        chk("rd_byte", 32'(b), hit ? 32'(pay[i]) : 32'hFF);
      end
    end
    if (fin) do_stop();
    clks(6);
    chk("tx_req_cnt", tx_cnt - tx0, (hit && rd) ? n : 0);
    chk("rx_valid_cnt", rx_cnt - rx0, (hit && !rd) ? n : 0);
    chk("pulse_1clk", long_cnt - lg0, 0);
    if (hit && !rd) begin
      for (int i = 0; i < n; i++) chk("rx_data", 32'(rx_log[8'(rx0 + i)]), 32'(pay[i]));
      chk("rx_hold", 32'(rx_data), 32'(pay[n - 1]));
    end
    if (!hit) chk("oe_quiet", oe_cnt - oe0, 0);
    if (fin) begin
      chk("busy_off", 32'(busy), 0);
      chk("state_idle", 32'(dut.state), 32'(IDLE));
    end
  endtask

  initial begin
    logic ack, oe, s, o;
    logic [7:0] b;
    logic [6:0] a;
    int lo0, tx0;
    for (int i = 0; i < 256; i++) plan[i] = 8'h00;
    for (int i = 0; i < 4; i++) pay[i] = 8'h00;

    // Reset state
    clks(4);
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_tx_req", 32'(tx_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    clks(4);

    // Write 0xA0, 0x3C, STOP
    pay[0] = 8'h3C;
    transfer(SLAVE, 1'b0, 1, 1'b1);

    // Read 0xA1, one byte 0x96, NACK
    pay[0] = 8'h96;
    transfer(SLAVE, 1'b1, 1, 1'b1);

    // Read two bytes 0x12, 0x34 (ACK then NACK)
    pay[0] = 8'h12; pay[1] = 8'h34;
    transfer(SLAVE, 1'b1, 2, 1'b1);

    // Foreign address 0x52, data 0xFF
    pay[0] = 8'hFF;
    transfer(7'h52, 1'b0, 1, 1'b1);

    // Write 0x55, repeated START, read 0xC3
    pay[0] = 8'h55;
    transfer(SLAVE, 1'b0, 1, 1'b0);
    lo0 = busy_lo;
    tx0 = tx_cnt;
    plan[8'(tx0)] = 8'hC3;
    do_start();
    wr_byte({SLAVE, 1'b1}, ack, oe);
    chk("rs_addr_ack", 32'(ack), 0);
    chk("rs_busy_held", busy_lo - lo0, 0);
    chk("rs_rx_keep", 32'(rx_data), 32'h55);
    rd_byte(1'b1, b);
    chk("rs_rd_byte", 32'(b), 32'hC3);
    do_stop();
    clks(6);
    chk("rs_tx_req_cnt", tx_cnt - tx0, 1);
    chk("rs_busy_off", 32'(busy), 0);

    // Reset in the middle of a read byte, then a normal write
    tx0 = tx_cnt;
    plan[8'(tx0)] = 8'h00;
    do_start();
    wr_byte({SLAVE, 1'b1}, ack, oe);
    for (int i = 0; i < 3; i++) bit_io(1'b1, s, o);
    clks(6);
    chk("pre_rst_oe", 32'(sda_oe), 1);
    rst = 1'b1;
    clks(1);
    chk("mid_rst_oe", 32'(sda_oe), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    do_stop();
    clks(4);
    pay[0] = 8'h0F;
    transfer(SLAVE, 1'b0, 1, 1'b1);

    // Random transfers
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(3) == 0) begin
        a = 7'($urandom);
        if (a == SLAVE) a = SLAVE + 7'd1;
      end else a = SLAVE;
      for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
      transfer(a, 1'($urandom_range(1)), int'($urandom_range(3, 1)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
